// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state encodings, opcode constants and ALU_OP codes for mc_ctrl_gen
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    // Opcodes are zero-extended to the instance's OPW by the users.
    localparam int unsigned OPC_NOOP = 0;
    localparam int unsigned OPC_LOD  = 1;
    localparam int unsigned OPC_STR  = 2;
    localparam int unsigned OPC_BRA  = 4;
    localparam int unsigned OPC_BRR  = 5;
    localparam int unsigned OPC_BNE  = 6;
    localparam int unsigned OPC_ALU  = 8;
    localparam int unsigned OPC_HLT  = 15;

    localparam logic [1:0] ALU_OP_REG  = 2'b00;
    localparam logic [1:0] ALU_OP_IMM  = 2'b01;
    localparam logic [1:0] ALU_OP_PASS = 2'b10;

endpackage

// File: rtl/mc_br_eval.sv
// rtl/mc_br_eval.sv - combinational branch-taken and target-mode evaluation
module mc_br_eval
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int CCW = 4
) (
    input  logic [OPW-1:0] op,
    input  logic [CCW-1:0] mm,
    input  logic [CCW-1:0] stat,
    output logic           is_branch,
    output logic           taken,
    output logic           br_abs
);

    localparam logic [OPW-1:0] OP_BRA = OPW'(OPC_BRA);
    localparam logic [OPW-1:0] OP_BRR = OPW'(OPC_BRR);
    localparam logic [OPW-1:0] OP_BNE = OPW'(OPC_BNE);

    logic hit;

    assign hit = |(mm & stat);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        br_abs    = 1'b0;
        if (op == OP_BRA) begin
            is_branch = 1'b1;
            taken     = (mm == '0) || hit;
            br_abs    = 1'b1;
        end else if (op == OP_BRR) begin
            is_branch = 1'b1;
            taken     = (mm == '0) || hit;
            br_abs    = 1'b0;
        end else if (op == OP_BNE) begin
            is_branch = 1'b1;
            taken     = !hit;
            br_abs    = 1'b1;
        end
    end

endmodule

// File: rtl/mc_ctrl_gen.sv
// rtl/mc_ctrl_gen.sv - multi-cycle processor control FSM with memory handshake, timeout and HALT
module mc_ctrl_gen
    import mc_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int CCW         = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int IMM_MODE    = 8
) (
    input  logic           CLK,
    input  logic           RST_F,
    input  logic [OPW-1:0] OPCODE,
    input  logic [CCW-1:0] MM,
    input  logic [CCW-1:0] STAT,
    input  logic           MEM_RDY,
    output logic           RF_WE,
    output logic           WB_SEL,
    output logic           RD_SEL,
    output logic [1:0]     ALU_OP,
    output logic           PC_SEL,
    output logic           PC_WRITE,
    output logic           PC_RST,
    output logic           BR_SEL,
    output logic           IR_LD,
    output logic           MEM_RE,
    output logic           MEM_WE,
    output logic           HALTED,
    output logic           ERR,
    output logic [2:0]     STATE
);

    localparam int CNTW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(MEM_TIMEOUT - 1);

    localparam logic [OPW-1:0] OP_LOD = OPW'(OPC_LOD);
    localparam logic [OPW-1:0] OP_STR = OPW'(OPC_STR);
    localparam logic [OPW-1:0] OP_BRA = OPW'(OPC_BRA);
    localparam logic [OPW-1:0] OP_BRR = OPW'(OPC_BRR);
    localparam logic [OPW-1:0] OP_BNE = OPW'(OPC_BNE);
    localparam logic [OPW-1:0] OP_ALU = OPW'(OPC_ALU);
    localparam logic [OPW-1:0] OP_HLT = OPW'(OPC_HLT);

    state_t          state;
    state_t          state_n;
    logic [OPW-1:0]  op_q;
    logic [CCW-1:0]  mm_q;
    logic [CNTW-1:0] wait_cnt;
    logic            err_q;

    logic q_alu, q_lod, q_str, q_imm;
    logic br_is, br_taken, br_abs;
    logic live_exec;
    logic mem_timeout;
    logic [1:0] alu_op_q;

    mc_br_eval #(
        .OPW (OPW),
        .CCW (CCW)
    ) u_br_eval (
        .op        (op_q),
        .mm        (mm_q),
        .stat      (STAT),
        .is_branch (br_is),
        .taken     (br_taken),
        .br_abs    (br_abs)
    );

    assign q_alu = (op_q == OP_ALU);
    assign q_lod = (op_q == OP_LOD);
    assign q_str = (op_q == OP_STR);
    assign q_imm = q_alu && (mm_q == CCW'(IMM_MODE));

    // Decoded on the live opcode because op_q only updates as DECODE is left.
    assign live_exec = (OPCODE == OP_LOD) || (OPCODE == OP_STR) || (OPCODE == OP_BRA) ||
                       (OPCODE == OP_BRR) || (OPCODE == OP_BNE) || (OPCODE == OP_ALU);

    assign mem_timeout = (state == ST_MEM) && (q_lod || q_str) && !MEM_RDY &&
                         (wait_cnt == WAIT_LAST);

    always_comb begin
        alu_op_q = ALU_OP_REG;
        if (q_imm || q_lod || q_str) begin
            alu_op_q = ALU_OP_IMM;
        end else if (br_is) begin
            alu_op_q = ALU_OP_PASS;
        end
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state    <= ST_START0;
            op_q     <= '0;
            mm_q     <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_DECODE) begin
                op_q <= OPCODE;
                mm_q <= MM;
            end
            if (state != ST_MEM) begin
                wait_cnt <= '0;
            end else if ((q_lod || q_str) && !MEM_RDY && !mem_timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (mem_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_START0: state_n = ST_START1;
            ST_START1: state_n = ST_FETCH;
            ST_FETCH:  state_n = ST_DECODE;
            ST_DECODE: begin
                if (OPCODE == OP_HLT) begin
                    state_n = ST_HALT;
                end else if (live_exec) begin
                    state_n = ST_EXECUTE;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                if (q_alu || q_lod || q_str) begin
                    state_n = ST_MEM;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (q_alu) begin
                    state_n = ST_WRITEBACK;
                end else if (MEM_RDY) begin
                    state_n = q_lod ? ST_WRITEBACK : ST_FETCH;
                end else if (mem_timeout) begin
                    state_n = ST_HALT;
                end
            end
            ST_WRITEBACK: state_n = ST_FETCH;
            ST_HALT:      state_n = ST_HALT;
            default:      state_n = ST_START0;
        endcase
    end

    always_comb begin
        RF_WE    = 1'b0;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        ALU_OP   = ALU_OP_REG;
        PC_SEL   = 1'b0;
        PC_WRITE = 1'b0;
        PC_RST   = 1'b0;
        BR_SEL   = 1'b0;
        IR_LD    = 1'b0;
        MEM_RE   = 1'b0;
        MEM_WE   = 1'b0;
        HALTED   = 1'b0;
        unique case (state)
            ST_START0, ST_START1: PC_RST = 1'b1;
            ST_FETCH: begin
                IR_LD    = 1'b1;
                PC_WRITE = 1'b1;
            end
            ST_EXECUTE: begin
                ALU_OP = alu_op_q;
                RD_SEL = q_imm;
                if (br_is) begin
                    BR_SEL   = br_abs;
                    PC_SEL   = br_taken;
                    PC_WRITE = br_taken;
                end
            end
            ST_MEM: begin
                ALU_OP = alu_op_q;
                RD_SEL = q_imm;
                MEM_RE = q_lod;
                MEM_WE = q_str;
            end
            ST_WRITEBACK: begin
                ALU_OP = alu_op_q;
                RD_SEL = q_imm;
                RF_WE  = q_alu || q_lod;
                WB_SEL = q_lod;
            end
            ST_HALT: HALTED = 1'b1;
            default: ;
        endcase
    end

    assign ERR   = err_q;
    assign STATE = state;

endmodule

// File: tb/tb_mc_ctrl_gen.sv
// tb/tb_mc_ctrl_gen.sv - randomized self-checking bench for mc_ctrl_gen against an instruction-level trace model
module tb_mc_ctrl_gen;

    localparam int T   = 15;
    localparam int IMM = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       rf_we;
        logic       wb_sel;
        logic       rd_sel;
        logic [1:0] alu_op;
        logic       pc_sel;
        logic       pc_write;
        logic       pc_rst;
        logic       br_sel;
        logic       ir_ld;
        logic       mem_re;
        logic       mem_we;
        logic       halted;
        logic       err;
    } out_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_rdy;
    logic       rf_we, wb_sel, rd_sel, pc_sel, pc_write, pc_rst, br_sel, ir_ld;
    logic       mem_re, mem_we, halted, err;
    logic [1:0] alu_op;
    logic [2:0] state;

    out_t got;
    out_t exp_q[$];
    logic m_err;
    int   total;
    int   bad;

    mc_ctrl_gen #(
        .OPW         (4),
        .CCW         (4),
        .MEM_TIMEOUT (T),
        .IMM_MODE    (IMM)
    ) dut (
        .CLK      (clk),
        .RST_F    (rst_n),
        .OPCODE   (opcode),
        .MM       (mm),
        .STAT     (stat),
        .MEM_RDY  (mem_rdy),
        .RF_WE    (rf_we),
        .WB_SEL   (wb_sel),
        .RD_SEL   (rd_sel),
        .ALU_OP   (alu_op),
        .PC_SEL   (pc_sel),
        .PC_WRITE (pc_write),
        .PC_RST   (pc_rst),
        .BR_SEL   (br_sel),
        .IR_LD    (ir_ld),
        .MEM_RE   (mem_re),
        .MEM_WE   (mem_we),
        .HALTED   (halted),
        .ERR      (err),
        .STATE    (state)
    );

    assign got = {state, rf_we, wb_sel, rd_sel, alu_op, pc_sel, pc_write, pc_rst,
                  br_sel, ir_ld, mem_re, mem_we, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            chk("cycle_outputs", 32'(got), 32'(e));
        end
    end

    function automatic out_t blank(input logic [2:0] s);
        out_t e;
        e        = '0;
        e.st     = s;
        e.pc_rst = (s == 3'd0) || (s == 3'd1);
        e.halted = (s == 3'd7);
        e.err    = m_err;
        return e;
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    task automatic cyc(input out_t e, input logic [3:0] st, input logic rdy,
                       input logic [3:0] opc, input logic [3:0] mmv);
        @(posedge clk);
        #1;
        stat    = st;
        mem_rdy = rdy;
        opcode  = opc;
        mm      = mmv;
        exp_q.push_back(e);
    endtask

    // One instruction from FETCH onwards; w = MEM cycles before MEM_RDY (w >= T never answers).
    task automatic run_instr(input int op, input logic [3:0] mmv, input int w, input int sf,
                             output int n, output logic tk);
        out_t       e;
        logic [3:0] st;
        logic [1:0] aop;
        logic       imm, hit, is_br, is_mem;
        n  = 0;
        tk = 1'b0;
        e = blank(3'd2); e.ir_ld = 1'b1; e.pc_write = 1'b1;
        cyc(e, rnd4(), rnd1(), rnd4(), rnd4()); n++;
        e = blank(3'd3);
        cyc(e, rnd4(), rnd1(), 4'(op), mmv); n++;
        if (op == 15) begin
            e = blank(3'd7);
            cyc(e, rnd4(), rnd1(), rnd4(), rnd4()); n++;
            return;
        end
        is_br  = op inside {4, 5, 6};
        is_mem = op inside {1, 2};
        if (!(is_br || is_mem || op == 8)) return;
        imm = (op == 8) && (mmv == 4'(IMM));
        aop = is_br ? 2'b10 : ((is_mem || imm) ? 2'b01 : 2'b00);
        st  = (sf < 0) ? rnd4() : 4'(sf);
        e = blank(3'd4); e.alu_op = aop; e.rd_sel = imm;
        if (is_br) begin
            hit        = (mmv & st) != 4'd0;
            tk         = (op == 6) ? !hit : ((mmv == 4'd0) || hit);
            e.br_sel   = (op != 5);
            e.pc_sel   = tk;
            e.pc_write = tk;
        end
        cyc(e, st, rnd1(), rnd4(), rnd4()); n++;
        if (is_br) return;
        if (op == 8) begin
            e = blank(3'd5); e.alu_op = aop; e.rd_sel = imm;
            cyc(e, rnd4(), rnd1(), rnd4(), rnd4()); n++;
        end else begin
            for (int k = 0; k < T; k++) begin
                e = blank(3'd5); e.alu_op = 2'b01; e.mem_re = (op == 1); e.mem_we = (op == 2);
                cyc(e, rnd4(), (k == w), rnd4(), rnd4()); n++;
                if (k == w) break;
            end
            if (w >= T) begin
                m_err = 1'b1;
                e = blank(3'd7);
                cyc(e, rnd4(), rnd1(), rnd4(), rnd4()); n++;
                return;
            end
            if (op == 2) return;
        end
        e = blank(3'd6); e.rf_we = 1'b1; e.wb_sel = (op == 1); e.alu_op = aop; e.rd_sel = imm;
        cyc(e, rnd4(), rnd1(), rnd4(), rnd4()); n++;
    endtask

    task automatic pulse_reset(input string tag);
        out_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_pc_rst"}, 32'(pc_rst), 32'd1);
        m_err = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        e = blank(3'd1);
        cyc(e, rnd4(), rnd1(), rnd4(), rnd4());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic tk;
        int   ops[10] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 12};
        out_t e;
        total   = 0;
        bad     = 0;
        m_err   = 1'b0;
        rst_n   = 1'b0;
        opcode  = '0;
        mm      = '0;
        stat    = '0;
        mem_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(got), 32'(blank(3'd0)));
        pulse_reset("boot");

        run_instr(8, 4'd8, 0, -1, n, tk);        chk("alu_imm_len", n, 5);
        run_instr(6, 4'b0010, 0, 0, n, tk);      chk("bne_taken", 32'(tk), 1); chk("bne_len", n, 3);
        run_instr(6, 4'b0010, 0, 2, n, tk);      chk("bne_not_taken", 32'(tk), 0);
        run_instr(5, 4'd0, 0, -1, n, tk);        chk("brr_mm0_taken", 32'(tk), 1);
        run_instr(4, 4'b0100, 0, 0, n, tk);      chk("bra_not_taken", 32'(tk), 0);
        run_instr(1, 4'd3, 3, -1, n, tk);        chk("lod_wait3_len", n, 8);
        run_instr(2, 4'd3, 0, -1, n, tk);        chk("str_wait0_len", n, 4);
        run_instr(0, 4'd0, 0, -1, n, tk);        chk("noop_len", n, 2);
        run_instr(9, 4'd1, 0, -1, n, tk);        chk("undef_len", n, 2);
        run_instr(8, 4'd3, 0, -1, n, tk);        chk("alu_reg_len", n, 5);

        for (int i = 0; i < 150; i++) begin
            int         op;
            logic [3:0] mv;
            op = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0:       mv = 4'd8;
                1:       mv = 4'd0;
                default: mv = rnd4();
            endcase
            run_instr(op, mv, $urandom_range(0, 5), -1, n, tk);
        end

        run_instr(1, 4'd0, T, -1, n, tk);        chk("lod_timeout_len", n, 19);
        repeat (3) begin
            e = blank(3'd7);
            cyc(e, rnd4(), 1'b1, rnd4(), rnd4());
        end
        @(negedge clk);
        chk("timeout_err", 32'(err), 32'd1);
        pulse_reset("after_timeout");

        run_instr(15, 4'd0, 0, -1, n, tk);       chk("hlt_len", n, 3);
        repeat (20) begin
            e = blank(3'd7);
            cyc(e, rnd4(), rnd1(), rnd4(), rnd4());
        end
        pulse_reset("after_hlt");

        e = blank(3'd2); e.ir_ld = 1'b1; e.pc_write = 1'b1;
        cyc(e, rnd4(), 1'b0, rnd4(), rnd4());
        e = blank(3'd3);
        cyc(e, rnd4(), 1'b0, 4'd8, 4'd8);
        @(posedge clk);
        #1;
        chk("exec_state", 32'(state), 32'd4);
        chk("exec_alu_op", 32'(alu_op), 32'd1);
        chk("exec_rd_sel", 32'(rd_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_pc_rst", 32'(pc_rst), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            chk("rst_hold_state", 32'(state), 32'd0);
        end
        #1;
        rst_n = 1'b1;
        m_err = 1'b0;
        e = blank(3'd1);
        cyc(e, rnd4(), 1'b0, rnd4(), rnd4());
        run_instr(8, 4'd8, 0, -1, n, tk);        chk("alu_after_reset_len", n, 5);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_gen.md
Name: mc_ctrl_gen

Overview:
- Parametrised multi-cycle processor control FSM; next generation of the core sequencer between the instruction register, register file, ALU, PC and data memory.
- Adds the following over the current controller:
  - a real HALT state in place of a simulation stop;
  - a data-memory ready handshake with timeout;
  - an early return to FETCH for branches;
  - a parametrised opcode / condition-code width.
- All datapath enables are a combinational decode of the registered state and the latched instruction fields.

Parameters:
OPW, 4, opcode field width (encodings in package, zero-extended to OPW)
CCW, 4, condition mask (MM) and status (STAT) width
MEM_TIMEOUT, 15, max MEM-state wait cycles before error; >=1
IMM_MODE, 8, MM value selecting immediate ALU operand

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  asynchronous active-low reset
OPCODE  in  OPW  opcode from instruction register
MM  in  CCW  mode/condition-mask field
STAT  in  CCW  ALU status flags
MEM_RDY  in  1  data memory access complete
RF_WE  out  1  register file write enable
WB_SEL  out  1  writeback source: 0 ALU, 1 memory
RD_SEL  out  1  ALU B operand: 0 register, 1 immediate
ALU_OP  out  2  00 reg arith, 01 imm arith, 10 pass/branch target
PC_SEL  out  1  PC source: 0 increment, 1 branch target
PC_WRITE  out  1  PC load enable
PC_RST  out  1  PC reset
BR_SEL  out  1  branch target: 0 relative, 1 absolute
IR_LD  out  1  instruction register load
MEM_RE  out  1  data memory read strobe
MEM_WE  out  1  data memory write strobe
HALTED  out  1  high in HALT
ERR  out  1  sticky memory-timeout flag
STATE  out  3  current state code (debug)

Behaviour:
- Reset:
  - RST_F low forces state START0 and clears ERR, op_q, mm_q and the wait counter immediately (asynchronous), including mid-instruction and mid-MEM wait.
  - In START0, outputs are PC_RST=1 and every other output 0.
- States and encodings: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Transitions:
  - START0→START1→FETCH→DECODE.
  - DECODE with OPCODE=hlt → HALT. DECODE with noop or an undefined opcode → FETCH. All other opcodes → EXECUTE.
  - EXECUTE with a branch (bra/brr/bne) → FETCH. EXECUTE with alu/lod/str → MEM.
  - MEM with alu → WRITEBACK.
  - MEM with lod/str: stay while MEM_RDY=0; on MEM_RDY=1 → WRITEBACK for lod, → FETCH for str. If the wait counter reaches MEM_TIMEOUT with MEM_RDY still 0 → HALT and set ERR.
  - WRITEBACK → FETCH.
  - HALT is absorbing until reset.
- Latching: op_q and mm_q capture OPCODE and MM on the rising edge that leaves DECODE. EXECUTE, MEM and WRITEBACK decode from op_q/mm_q only.
- START0/START1: PC_RST=1, all other outputs 0.
- FETCH: IR_LD=1, PC_WRITE=1, PC_SEL=0.
- DECODE: all enables 0.
- RD_SEL: 1 in EXECUTE, MEM and WRITEBACK when op_q=alu and mm_q=IMM_MODE; otherwise 0.
- ALU_OP in EXECUTE, MEM and WRITEBACK:
  - alu with immediate → 01; alu with register → 00;
  - lod/str → 01 (base+offset);
  - branch → 10;
  - 00 in all other states.
- Branch condition, evaluated in EXECUTE on the live STAT:
  - bra: taken if mm_q=0 or (mm_q & STAT)≠0; BR_SEL=1.
  - brr: same condition; BR_SEL=0.
  - bne: taken if (mm_q & STAT)=0; BR_SEL=1.
  - Taken: PC_SEL=1 and PC_WRITE=1 in that cycle. Not taken: PC_WRITE=0.
- MEM: MEM_RE=1 (lod) or MEM_WE=1 (str) for every MEM cycle, including the MEM_RDY cycle.
  - The wait counter resets on entry to MEM and increments each cycle MEM_RDY=0.
  - MEM_RDY in the first MEM cycle gives zero wait.
- WRITEBACK: RF_WE=1 for alu and lod. WB_SEL=1 for lod, 0 otherwise.
- HALT: HALTED=1, all enables 0, ERR held.
- Cycle counts per instruction:
  - alu: 5 cycles (FETCH…WRITEBACK);
  - branch: 3 cycles;
  - noop: 2 cycles;
  - lod: 5+wait cycles;
  - str: 4+wait cycles.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encodings;
  - the opcode constants noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu=8, hlt=15;
  - the ALU_OP codes.
- One sub-module, mc_br_eval: combinational branch-taken evaluation from op_q, mm_q and STAT, parametrised by CCW.

Test Plan:
- Reset then alu immediate (OPCODE=8, MM=8) → PC_RST=1 for 2 cycles. FETCH shows IR_LD=PC_WRITE=1. EXECUTE shows ALU_OP=01, RD_SEL=1. WRITEBACK shows RF_WE=1, WB_SEL=0. Next cycle is FETCH.
- bne with MM=4'b0010: STAT=4'b0000 → EXECUTE shows PC_SEL=PC_WRITE=BR_SEL=1, then FETCH. STAT=4'b0010 → PC_WRITE=0 in EXECUTE, then FETCH.
- brr with MM=0 → always taken with BR_SEL=0. bra with MM=4'b0100, STAT=4'b0000 → not taken.
- lod with MEM_RDY raised after 3 MEM cycles → MEM_RE=1 for 4 cycles, then WRITEBACK with RF_WE=WB_SEL=1. str with MEM_RDY in the first cycle → one MEM cycle with MEM_WE=1, then FETCH.
- lod with MEM_RDY held 0 and MEM_TIMEOUT=15 → after 15 MEM cycles, state HALT with HALTED=ERR=1. Then RST_F pulse → START0 with ERR=0.
- hlt (OPCODE=15) → DECODE→HALT, which persists for 20 cycles. Drop RST_F mid-EXECUTE of a later alu → STATE=0 without waiting for a clock edge, and RF_WE is never asserted.
